bram_fifo: RTL and testbench

Synchronous single-clock FIFO built on the team's simple dual-port BRAM (1-cycle registered read, write-to-read bypass on address match). Valid/ready on both sides; first-word-fall-through output, so the head word is presented without a read request. Sits between producer stages and consumers wherever BRAM-depth buffering is needed (stream decoupling, rate matching).

---
 rtl/bram_fifo_pkg.sv | 7 +
 rtl/bram_fifo_if.sv | 24 ++
 rtl/bram_fifo_bram.sv | 28 ++
 rtl/bram_fifo.sv | 70 +++++++
 tb/tb_bram_fifo.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared defaults for the BRAM-backed FIFO slice.
package bram_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/bram_fifo_if.sv
// Valid/ready write and read channels of the FIFO.
// The producer/consumer side uses the master modport; the FIFO uses the slave modport.
interface bram_fifo_if import bram_fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/bram_fifo_bram.sv
// Simple dual-port BRAM with a registered read port.
// A write to the address being read is forwarded straight to read_data.
module dual_port_bram import bram_fifo_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[write_addr] <= write_data;
        end
        if (wr_en && (write_addr == read_addr)) begin
            read_data <= write_data;
        end else begin
            read_data <= mem_q[read_addr];
        end
    end

endmodule

// File: rtl/bram_fifo.sv
// Single-clock first-word-fall-through FIFO on top of dual_port_bram.
// The BRAM output register doubles as the output stage, so the full depth is usable.
module bram_fifo import bram_fifo_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    bram_fifo_if.slave        bus,
    output logic [ADDR_WIDTH:0] count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                rd_valid_q, rd_valid_d;
    logic                push, pop;

    assign full         = (count_q == DEPTH);
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign bus.wr_ready = !full;
    assign bus.rd_valid = rd_valid_q;
    assign push         = bus.wr_valid && !full;
    assign pop          = rd_valid_q && bus.rd_ready;

    // rd_ptr_d is the head after this edge; reading it now keeps read_data equal to the head word.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop};
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        rd_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    dual_port_bram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bram (
        .clk        (clk),
        .wr_en      (push && !reset),
        .write_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .write_data (bus.wr_data),
        .read_addr  (rd_ptr_d[ADDR_WIDTH-1:0]),
        .read_data  (bus.rd_data)
    );

endmodule

// File: tb/tb_bram_fifo.sv
// Directed and randomized self-checking bench for bram_fifo with an 8-deep configuration.
module tb_bram_fifo;

    localparam int AW = 3;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int assertionCount = 0;
    int failCount      = 0;

    bram_fifo_if #(.DATA_WIDTH(DW)) bus ();

    bram_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertionCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic rr);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic fillWords(input logic [DW-1:0] base);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, base + DW'(i), 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    // Random phase state: reference queue plus last-cycle stall snapshot.
    logic [DW-1:0] refQ[$];
    logic [DW-1:0] prevData;
    logic          stallPrev;
    logic          wv, rr;
    logic [DW-1:0] d;
    int            sent, got, inIdx, outIdx;

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);

        doReset();
        checkOutput("reset wr_ready", bus.wr_ready, 1);
        checkOutput("reset rd_valid", bus.rd_valid, 0);
        checkOutput("reset count", count, 0);
        checkOutput("reset full", full, 0);
        checkOutput("reset empty", empty, 1);

        applyStimulus(1'b1, 32'hA5A5_0001, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("fwft rd_valid", bus.rd_valid, 1);
        checkOutput("fwft rd_data", bus.rd_data, 32'hA5A5_0001);
        checkOutput("fwft count", count, 1);
        checkOutput("fwft empty", empty, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("hold valid %0d", i), bus.rd_valid, 1);
            checkOutput($sformatf("hold data %0d", i), bus.rd_data, 32'hA5A5_0001);
        end
        applyStimulus(1'b0, '0, 1'b1);
        step();
        checkOutput("single drain empty", empty, 1);
        checkOutput("single drain rd_valid", bus.rd_valid, 0);

        doReset();
        fillWords(32'h0);
        checkOutput("fill full", full, 1);
        checkOutput("fill wr_ready", bus.wr_ready, 0);
        checkOutput("fill count", count, 8);
        applyStimulus(1'b1, 32'h99, 1'b0);
        step();
        checkOutput("ninth ignored count", count, 8);
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("drain valid %0d", i), bus.rd_valid, 1);
            checkOutput($sformatf("drain data %0d", i), bus.rd_data, i);
            step();
        end
        checkOutput("drain empty", empty, 1);
        checkOutput("drain rd_valid", bus.rd_valid, 0);

        doReset();
        inIdx  = 0;
        outIdx = 0;
        for (int cyc = 0; cyc < 200 && outIdx < 40; cyc++) begin
            applyStimulus(inIdx < 40, 32'h3000 + inIdx, 1'b1);
            checkOutput("stream count bound", count <= 2, 1);
            if (outIdx > 0 && outIdx < 40) checkOutput($sformatf("stream bubble %0d", outIdx), bus.rd_valid, 1);
            if (bus.rd_valid) begin
                checkOutput($sformatf("stream data %0d", outIdx), bus.rd_data, 32'h3000 + outIdx);
                outIdx++;
            end
            if (bus.wr_valid && bus.wr_ready) inIdx++;
            step();
        end
        checkOutput("stream words out", outIdx, 40);
        applyStimulus(1'b0, '0, 1'b0);

        doReset();
        fillWords(32'h100);
        applyStimulus(1'b1, 32'hDEAD, 1'b1);
        checkOutput("full pushpop wr_ready", bus.wr_ready, 0);
        step();
        checkOutput("full pushpop count", count, 7);
        checkOutput("full pushpop wr_ready after", bus.wr_ready, 1);
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            checkOutput($sformatf("full drain data %0d", i), bus.rd_data, 32'h100 + i);
            step();
        end
        checkOutput("full drain empty", empty, 1);

        doReset();
        applyStimulus(1'b1, 32'h11, 1'b0);
        step();
        checkOutput("one word data", bus.rd_data, 32'h11);
        applyStimulus(1'b1, 32'h22, 1'b1);
        step();
        checkOutput("one pushpop valid", bus.rd_valid, 1);
        checkOutput("one pushpop data", bus.rd_data, 32'h22);
        checkOutput("one pushpop count", count, 1);
        applyStimulus(1'b0, '0, 1'b1);
        step();
        checkOutput("one pushpop drained", empty, 1);

        doReset();
        refQ.delete();
        sent      = 0;
        got       = 0;
        stallPrev = 1'b0;
        prevData  = '0;
        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            wv = (sent < 10000) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            d  = $urandom;
            applyStimulus(wv, d, rr);
            if (stallPrev) begin
                checkOutput("stall valid", bus.rd_valid, 1);
                checkOutput("stall data", bus.rd_data, prevData);
            end
            checkOutput("rnd count", count, refQ.size());
            checkOutput("rnd valid", bus.rd_valid, refQ.size() != 0);
            checkOutput("rnd wr_ready", bus.wr_ready, refQ.size() < 8);
            if (bus.rd_valid && rr) begin
                if (refQ.size() == 0) checkOutput("rnd spurious", bus.rd_valid, 0);
                else checkOutput($sformatf("rnd data %0d", got), bus.rd_data, refQ.pop_front());
                got++;
            end
            if (wv && bus.wr_ready) begin
                refQ.push_back(d);
                sent++;
            end
            stallPrev = bus.rd_valid && !rr;
            prevData  = bus.rd_data;
            step();
        end
        checkOutput("rnd words out", got, 10000);

        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h500 + i, 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("pre midreset count", count, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("midreset count", count, 0);
        checkOutput("midreset rd_valid", bus.rd_valid, 0);
        applyStimulus(1'b1, 32'h77, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post reset data", bus.rd_data, 32'h77);
        checkOutput("post reset count", count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
        $finish;
    end

endmodule
